// File: rtl/qsgmii_mon_pkg.sv
// ---------------------------------------------------------------------------
// qsgmii_mon_pkg
// Shared definitions for the QSGMII link monitor: per-channel FSM state
// encoding, speed codes as reported by the QSGMII core, the speed value
// presented while in reset, and a counter-width helper.
// ---------------------------------------------------------------------------
package qsgmii_mon_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_UP      = 2'd2,
        ST_RESTART = 2'd3
    } link_state_t;

    localparam logic [1:0] SPD_10    = 2'b00;
    localparam logic [1:0] SPD_100   = 2'b01;
    localparam logic [1:0] SPD_1G    = 2'b10;
    localparam logic [1:0] SPD_RSVD  = 2'b11;
    localparam logic [1:0] SPD_RESET = SPD_1G;

    // Bits needed to hold 0..max_value; never less than one bit so that
    // degenerate parameter choices still produce a legal vector.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/qsgmii_link_mon_ch.sv
// ---------------------------------------------------------------------------
// qsgmii_link_mon_ch
// One channel of the QSGMII link monitor: 2-flop synchronizers on the raw
// link/speed status, a DOWN/QUAL/UP/RESTART state machine with debounce,
// down-timer and restart-pulse counters.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   link_in         raw link status (asynchronous to clk)
//   speed_in        raw speed code (asynchronous to clk)
//   link_up         debounced link state
//   link_change     one-cycle pulse on every link_up transition
//   an_restart_req  auto-negotiation restart request
//   speed_out       debounced speed code
// ---------------------------------------------------------------------------
module qsgmii_link_mon_ch
    import qsgmii_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESTART_TIMEOUT = 1250000,
    parameter int RESTART_PULSE   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_in,
    input  logic [1:0] speed_in,
    output logic       link_up,
    output logic       link_change,
    output logic       an_restart_req,
    output logic [1:0] speed_out
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int TMR_W = cnt_width(RESTART_TIMEOUT - 1);
    localparam int PUL_W = cnt_width(RESTART_PULSE - 1);

    // The sample that starts a candidate run leaves the counter at 0, so the
    // DEBOUNCE_CYCLES-th identical sample arrives while it reads D-2.
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESTART_TIMEOUT - 1);
    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RESTART_PULSE - 1);

    logic [1:0]       link_sync_reg;
    logic [1:0]       speed_sync1_reg;
    logic [1:0]       speed_sync2_reg;
    logic             link_s;
    logic [1:0]       speed_s;

    link_state_t      state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [DB_W-1:0]  db_cnt_reg;
    logic [PUL_W-1:0] pulse_cnt_reg;
    logic [1:0]       cand_reg;       // speed value currently being debounced
    logic             link_up_reg;
    logic             link_change_reg;
    logic             restart_req_reg;
    logic [1:0]       speed_out_reg;

    // Synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_sync_reg   <= '0;
            speed_sync1_reg <= '0;
            speed_sync2_reg <= '0;
        end else begin
            link_sync_reg   <= {link_sync_reg[0], link_in};
            speed_sync1_reg <= speed_in;
            speed_sync2_reg <= speed_sync1_reg;
        end
    end

    assign link_s  = link_sync_reg[1];
    assign speed_s = speed_sync2_reg;

    // Channel FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_DOWN;
            timer_reg       <= '0;
            db_cnt_reg      <= '0;
            pulse_cnt_reg   <= '0;
            cand_reg        <= SPD_RESET;
            link_up_reg     <= 1'b0;
            link_change_reg <= 1'b0;
            restart_req_reg <= 1'b0;
            speed_out_reg   <= SPD_RESET;
        end else begin
            link_change_reg <= 1'b0;
            case (state_reg)
                ST_DOWN: begin
                    if (link_s) begin
                        // This sample is the first of the debounce run.
                        state_reg  <= ST_QUAL;
                        cand_reg   <= speed_s;
                        db_cnt_reg <= '0;
                    end else if (timer_reg == TMR_LAST) begin
                        state_reg       <= ST_RESTART;
                        restart_req_reg <= 1'b1;
                        pulse_cnt_reg   <= '0;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                ST_QUAL: begin
                    if (!link_s) begin
                        state_reg <= ST_DOWN;
                        timer_reg <= '0;
                    end else if (speed_s != cand_reg || speed_s == SPD_RSVD) begin
                        cand_reg   <= speed_s;
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        state_reg       <= ST_UP;
                        link_up_reg     <= 1'b1;
                        link_change_reg <= 1'b1;
                        speed_out_reg   <= cand_reg;
                        db_cnt_reg      <= '0;
                    end else if (db_cnt_reg != DB_MAX) begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end

                ST_UP: begin
                    // Link loss wins over any concurrent speed change.
                    if (!link_s) begin
                        state_reg       <= ST_DOWN;
                        link_up_reg     <= 1'b0;
                        link_change_reg <= 1'b1;
                        timer_reg       <= '0;
                    end else if (speed_s != cand_reg) begin
                        cand_reg   <= speed_s;
                        db_cnt_reg <= '0;
                    end else if (cand_reg == speed_out_reg || cand_reg == SPD_RSVD) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        speed_out_reg <= cand_reg;
                        db_cnt_reg    <= '0;
                    end else if (db_cnt_reg != DB_MAX) begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end

                ST_RESTART: begin
                    // Link status is deliberately not looked at here.
                    if (pulse_cnt_reg == PUL_LAST) begin
                        state_reg       <= ST_DOWN;
                        restart_req_reg <= 1'b0;
                        timer_reg       <= '0;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
                    end
                end

                default: state_reg <= ST_DOWN;
            endcase
        end
    end

    assign link_up        = link_up_reg;
    assign link_change    = link_change_reg;
    assign an_restart_req = restart_req_reg;
    assign speed_out      = speed_out_reg;

endmodule

// File: rtl/qsgmii_link_monitor.sv
// ---------------------------------------------------------------------------
// qsgmii_link_monitor
// Debounces the four per-channel link/speed status outputs of one QSGMII
// core and requests auto-negotiation restarts on channels that stay down.
// Channels are fully independent.
//
// Ports
//   clk                         system clock
//   rst_n                       asynchronous active-low reset
//   status_link_in[3:0]         raw link status, bit n = channel n
//   status_speed_in_ch0..ch3    raw speed code per channel
//   status_speed_out_ch0..ch3   debounced speed code per channel
//   link_up[3:0]                debounced link state
//   link_change[3:0]            one-cycle pulse on link_up transitions
//   an_restart_req[3:0]         auto-negotiation restart request
// ---------------------------------------------------------------------------
module qsgmii_link_monitor
    import qsgmii_mon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RESTART_TIMEOUT = 1250000,
    parameter int RESTART_PULSE   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] status_link_in,
    input  logic [1:0]        status_speed_in_ch0,
    input  logic [1:0]        status_speed_in_ch1,
    input  logic [1:0]        status_speed_in_ch2,
    input  logic [1:0]        status_speed_in_ch3,
    output logic [1:0]        status_speed_out_ch0,
    output logic [1:0]        status_speed_out_ch1,
    output logic [1:0]        status_speed_out_ch2,
    output logic [1:0]        status_speed_out_ch3,
    output logic [NUM_CH-1:0] link_up,
    output logic [NUM_CH-1:0] link_change,
    output logic [NUM_CH-1:0] an_restart_req
);

    logic [1:0] speed_in_arr  [NUM_CH];
    logic [1:0] speed_out_arr [NUM_CH];

    assign speed_in_arr[0] = status_speed_in_ch0;
    assign speed_in_arr[1] = status_speed_in_ch1;
    assign speed_in_arr[2] = status_speed_in_ch2;
    assign speed_in_arr[3] = status_speed_in_ch3;

    assign status_speed_out_ch0 = speed_out_arr[0];
    assign status_speed_out_ch1 = speed_out_arr[1];
    assign status_speed_out_ch2 = speed_out_arr[2];
    assign status_speed_out_ch3 = speed_out_arr[3];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            qsgmii_link_mon_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESTART_TIMEOUT (RESTART_TIMEOUT),
                .RESTART_PULSE   (RESTART_PULSE)
            ) u_ch (
                .clk            (clk),
                .rst_n          (rst_n),
                .link_in        (status_link_in[gi]),
                .speed_in       (speed_in_arr[gi]),
                .link_up        (link_up[gi]),
                .link_change    (link_change[gi]),
                .an_restart_req (an_restart_req[gi]),
                .speed_out      (speed_out_arr[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_qsgmii_link_monitor.sv
// ---------------------------------------------------------------------------
// tb_qsgmii_link_monitor
// Directed scenarios followed by randomized link/speed activity on all four
// channels. A run-length based reference model predicts every output each
// cycle; directed scenarios add explicit timing checks.
// ---------------------------------------------------------------------------
module tb_qsgmii_link_monitor;

    localparam int D  = 4;
    localparam int RT = 20;
    localparam int P  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] link_in;
    logic [7:0] spd_in;
    logic [1:0] spd_out0, spd_out1, spd_out2, spd_out3;
    logic [3:0] link_up, link_change, an_restart_req;
    logic [7:0] spd_out_all;

    assign spd_out_all = {spd_out3, spd_out2, spd_out1, spd_out0};

    always #5 clk = ~clk;

    qsgmii_link_monitor #(
        .DEBOUNCE_CYCLES (D),
        .RESTART_TIMEOUT (RT),
        .RESTART_PULSE   (P)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .status_link_in       (link_in),
        .status_speed_in_ch0  (spd_in[1:0]),
        .status_speed_in_ch1  (spd_in[3:2]),
        .status_speed_in_ch2  (spd_in[5:4]),
        .status_speed_in_ch3  (spd_in[7:6]),
        .status_speed_out_ch0 (spd_out0),
        .status_speed_out_ch1 (spd_out1),
        .status_speed_out_ch2 (spd_out2),
        .status_speed_out_ch3 (spd_out3),
        .link_up              (link_up),
        .link_change          (link_change),
        .an_restart_req       (an_restart_req)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Per channel: raw samples pass a two-deep delay line. While not up, the
    // link qualifies once D consecutive link-high samples carry the same
    // valid speed. While up, a new valid speed replaces the output after a
    // run of D identical samples. Restart blinds the channel for P samples.
    int m_d1_l [4], m_d2_l [4], m_d1_s [4], m_d2_s [4];
    int m_up [4], m_spd [4], m_quiet [4], m_blind [4], m_prev [4];
    int m_rlen [4], m_rval [4];
    logic [3:0] exp_up, exp_chg, exp_req;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_d1_l[c] = 0; m_d2_l[c] = 0; m_d1_s[c] = 0; m_d2_s[c] = 0;
            m_up[c] = 0; m_spd[c] = 2; m_quiet[c] = 0; m_blind[c] = 0;
            m_prev[c] = 0; m_rlen[c] = 0; m_rval[c] = 0;
        end
        exp_up = '0; exp_chg = '0; exp_req = '0;
    endtask

    task automatic model_step();
        int l, v;
        for (int c = 0; c < 4; c++) begin
            l = m_d2_l[c];
            v = m_d2_s[c];
            m_d2_l[c] = m_d1_l[c];
            m_d2_s[c] = m_d1_s[c];
            m_d1_l[c] = int'(link_in[c]);
            m_d1_s[c] = int'(spd_in[2*c +: 2]);
            exp_chg[c] = 1'b0;
            if (m_blind[c] > 0) begin
                m_blind[c]--;
                if (m_blind[c] == 0) begin
                    exp_req[c] = 1'b0;
                    m_quiet[c] = 0; m_prev[c] = 0; m_rlen[c] = 0;
                end
            end else if (m_up[c] != 0) begin
                if (l == 0) begin
                    m_up[c] = 0; exp_chg[c] = 1'b1;
                    m_quiet[c] = 0; m_prev[c] = 0; m_rlen[c] = 0;
                end else begin
                    if (m_rlen[c] > 0 && v == m_rval[c]) m_rlen[c]++;
                    else begin m_rval[c] = v; m_rlen[c] = 1; end
                    if (v != 3 && v != m_spd[c] && m_rlen[c] == D) m_spd[c] = v;
                end
            end else if (l != 0) begin
                if (m_rlen[c] > 0 && v == m_rval[c]) m_rlen[c]++;
                else begin m_rval[c] = v; m_rlen[c] = 1; end
                m_prev[c] = 1;
                if (v != 3 && m_rlen[c] == D) begin
                    m_up[c] = 1; exp_chg[c] = 1'b1; m_spd[c] = v;
                end
            end else begin
                m_rlen[c] = 0;
                if (m_prev[c] != 0) begin
                    m_prev[c] = 0; m_quiet[c] = 0;
                end else if (m_quiet[c] == RT - 1) begin
                    m_blind[c] = P; exp_req[c] = 1'b1; m_quiet[c] = 0;
                end else begin
                    m_quiet[c]++;
                end
            end
            exp_up[c] = (m_up[c] != 0);
        end
    endtask

    function automatic logic [7:0] exp_spd_all();
        logic [7:0] r;
        for (int c = 0; c < 4; c++) r[2*c +: 2] = 2'(m_spd[c]);
        return r;
    endfunction

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_val("link_up", link_up, exp_up);
        check_val("link_change", link_change, exp_chg);
        check_val("an_restart_req", an_restart_req, exp_req);
        check_val("speed_out", spd_out_all, exp_spd_all());
    end

    // ---------------- stimulus ----------------
    int lat, hi_len, period, fell, seen;

    initial begin
        model_reset();
        rst_n   = 1'b0;
        link_in = '0;
        spd_in  = '0;
        repeat (3) @(negedge clk);
        check_val("reset_speed_out", spd_out_all, 8'hAA);
        rst_n = 1'b1;
        @(negedge clk);

        // ch0 qualification latency: 2 sync + D debounce
        link_in[0] = 1'b1; spd_in[1:0] = 2'b01;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #2;
            if (link_up[0]) lat = i;
        end
        check_val("ch0_qual_latency", lat, 6);
        check_val("ch0_speed", spd_out0, 2'b01);

        // ch1 up at 1G, 2-cycle glitch, re-qualify
        @(negedge clk);
        link_in[1] = 1'b1; spd_in[3:2] = 2'b10;
        repeat (15) @(negedge clk);
        check_val("ch1_up", link_up[1], 1'b1);
        link_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        link_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        check_val("ch1_glitch_down", link_up[1], 1'b0);
        repeat (6) @(negedge clk);
        check_val("ch1_requal", link_up[1], 1'b1);

        // ch1 toggling speed never qualifies
        link_in[1] = 1'b0;
        repeat (4) @(negedge clk);
        link_in[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            spd_in[3:2] = (i % 2 == 0) ? 2'b00 : 2'b01;
            @(negedge clk);
        end
        check_val("ch1_toggle_noqual", link_up[1], 1'b0);
        spd_in[3:2] = 2'b10;
        repeat (10) @(negedge clk);
        check_val("ch1_hold_qual", link_up[1], 1'b1);

        // ch2 up at 100M, reserved code ignored, then 00 debounced
        link_in[2] = 1'b1; spd_in[5:4] = 2'b01;
        repeat (15) @(negedge clk);
        check_val("ch2_up", link_up[2], 1'b1);
        spd_in[5:4] = 2'b11;
        repeat (10) @(negedge clk);
        check_val("ch2_rsvd_hold", spd_out2, 2'b01);
        spd_in[5:4] = 2'b00;
        repeat (5) @(posedge clk);
        #2 check_val("ch2_spd_early", spd_out2, 2'b01);
        @(posedge clk);
        #2 check_val("ch2_spd_update", spd_out2, 2'b00);

        // ch3 held down: restart pulse width and period
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(posedge clk); #2;
            if (an_restart_req[3]) seen = 1;
        end
        check_val("ch3_restart_seen", seen, 1);
        check_val("others_no_restart", an_restart_req[2:0], 3'b000);
        hi_len = 1; period = 0; fell = 0;
        for (int i = 1; i <= 60 && period == 0; i++) begin
            @(posedge clk); #2;
            if (fell == 0) begin
                if (an_restart_req[3]) hi_len++;
                else fell = 1;
            end else if (an_restart_req[3]) begin
                period = i;
            end
        end
        check_val("ch3_restart_width", hi_len, P);
        check_val("ch3_restart_period", period, RT + P);

        // reset asserted in the middle of a restart pulse
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(posedge clk); #2;
            if (an_restart_req[3]) seen = 1;
        end
        check_val("ch3_restart_again", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("rst_req_drop", an_restart_req, 4'h0);
        check_val("rst_link_up", link_up, 4'h0);
        check_val("rst_speed", spd_out_all, 8'hAA);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // randomized activity
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7 + 8 * c) == 0) link_in[c] = ~link_in[c];
                if ($urandom_range(0, 5) == 0) spd_in[2*c +: 2] = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
